// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - N-to-1 valid/ready multiplexer with registered output and fixed/round-robin arbitration
//
// Parameters:
//   N     number of input channels (2..16)
//   W     data width per channel in bits (1..64)
//   SELW  width of sel / out_ch (derived from N)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin arbitration
//   sel        channel index used when mode = 0
//   in_data    packed channel data, channel c at [c*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered output word
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
//   out_ch     channel that supplied out_data
//
// Optional feature, enabled by defining RR_MUX_PKT_LOCK_EN:
//   in_last    per-channel end-of-packet marker
//   out_last   registered end-of-packet marker for out_data
//   A transfer with in_last = 0 locks the grant to that channel until its
//   in_last = 1 transfer, in either mode.

module rr_mux #(
    parameter int N    = 4,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [N-1:0]    in_last,
    output logic            out_last,
`endif
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_ch
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic            load_en;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic            xfer;
    logic [SELW-1:0] grant_next;

`ifdef RR_MUX_PKT_LOCK_EN
    logic            lock;
    logic [SELW-1:0] lock_ch;
`endif

    assign out_valid = (state == FULL);

    // The register can take a new word when empty or when it is being drained
    // on this same edge, which gives one word per cycle.
    assign load_en = (state == EMPTY) || out_ready;

    // Grant selection; deliberately independent of in_ready.
    always_comb begin
        int  idx;
        logic found;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        found     = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
        if (lock) begin
            grant_vld = in_valid[lock_ch];
            grant_idx = lock_ch;
        end else
`endif
        if (!mode) begin
            // Matching against each legal index keeps sel >= N from ever granting.
            for (int c = 0; c < N; c++) begin
                if (sel == SELW'(c) && in_valid[c]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(c);
                end
            end
        end else begin
            // Search ptr, ptr+1, ..., wrapping back to ptr-1.
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && in_valid[idx]) begin
                    found     = 1'b1;
                    grant_vld = 1'b1;
                    grant_idx = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && grant_vld && load_en) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer       = rst_n && grant_vld && load_en;
    assign grant_next = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SELW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last <= 1'b0;
            lock     <= 1'b0;
            lock_ch  <= '0;
`endif
        end else begin
            if (xfer) begin
                state    <= FULL;
                out_data <= in_data[int'(grant_idx)*W +: W];
                out_ch   <= grant_idx;
`ifdef RR_MUX_PKT_LOCK_EN
                out_last <= in_last[grant_idx];
                lock     <= !in_last[grant_idx];
                lock_ch  <= grant_idx;
                // Mid-packet words do not move the round-robin pointer.
                if (mode && in_last[grant_idx]) begin
                    ptr <= grant_next;
                end
`else
                if (mode) begin
                    ptr <= grant_next;
                end
`endif
            end else if (out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
